mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Multi-cycle controller for the RV32 subset core: ADD/SUB/AND/OR/XOR/SLT, ADDI, BEQ/BNE, JAL, JALR, LW, SW. It sequences instruction fetch, decode, execute, memory and writeback over several cycles. Instruction and data traffic share one memory port with a ready handshake. The block sits between the unified memory port and the existing ALU/register-file/PC datapath. It owns the instruction register (IR) and per-cycle enables, and traps on illegal opcodes or memory timeouts.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles to wait for `mem_ready` in one access before trapping; legal range 2..255.
- `clk` in 1: rising-edge clock.
- `nrst` in 1: asynchronous assert, active-low reset.
- `mem_rdata` in 32: read data from the shared memory.
- `mem_ready` in 1: memory completes the current access this cycle.
- `zero` in 1: ALU zero flag from the EXEC-cycle compare.
- `mem_req` out 1: memory access request.
- `mem_addr_sel` out 1: 0 = PC, 1 = ALU result.
- `mem_wr` out 1: write strobe, valid with `mem_req`.
- `ir` out 32: latched instruction.
- `pc_wr` out 1: PC update enable.
- `pc_src` out 2: PC source; 00 = PC+4, 01 = branch target, 10 = jump target (JAL: PC+imm; JALR: ALU result).
- `alu_src` out 1: 1 = immediate as ALU operand B.
- `alu_op` out 3: ALU operation code.
- `mdr_wr` out 1: latch `mem_rdata` into the datapath MDR.
- `reg_wr` out 1: register-file write enable.
- `memtoreg` out 2: writeback select; 00 = ALU, 01 = MDR, 10 = PC+4.
- `halted` out 1: sticky trap indicator.
- `trap_cause` out 2: 00 = none, 01 = illegal opcode, 10 = fetch timeout, 11 = data timeout.

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **Reset:** `nrst` low forces state IDLE, `ir` = 0, wait counter = 0, `trap_cause` = 00. All outputs are 0 while in reset and in IDLE.
- **IDLE:** one cycle only, then FETCH.
- **FETCH:**
  - Asserts `mem_req` with `mem_addr_sel` = 0.
  - On `mem_ready`: `ir` <= `mem_rdata`, `pc_wr` = 1 with `pc_src` = 00, go to DECODE.
  - Otherwise increment the wait counter. When the counter reaches `MEM_TIMEOUT` - 1 without ready, go to TRAP with cause 10.
- **DECODE:** one cycle, decodes `ir[6:0]`.
  - Legal opcodes are 0110011, 0010011, 1100011, 1101111, 1100111, 0000011, 0100011; these go to EXEC.
  - Any other opcode goes to TRAP with cause 01.
- **EXEC:** one cycle.
  - R-type: `alu_op` from funct3. funct3 000 gives SUB when funct7 = 0100000, else ADD. Unlisted funct3 gives ADD. Next state WB.
  - ADDI: `alu_src` = 1, `alu_op` = ADDI, next state WB.
  - Branch: `alu_op` = SUB. `pc_wr` = 1 with `pc_src` = 01 when (funct3 = 000 and `zero`) or (funct3 = 001 and not `zero`). Next state FETCH.
  - JAL/JALR: `reg_wr` = 1, `memtoreg` = 10, `pc_wr` = 1, `pc_src` = 10. JALR also sets `alu_src` = 1 and `alu_op` = ADD. Next state FETCH.
  - LW/SW: `alu_src` = 1, `alu_op` = ADD, next state MEM.
- **MEM:**
  - `mem_req` = 1, `mem_addr_sel` = 1, `mem_wr` = 1 for SW. `alu_src`/`alu_op` are held from EXEC so the address stays stable.
  - On `mem_ready`: SW goes to FETCH; LW pulses `mdr_wr` and goes to WB.
  - Timeout follows the FETCH rule, with cause 11.
- **WB:** `reg_wr` = 1, `memtoreg` = 01 for LW, else 00. Next state FETCH.
- **TRAP:**
  - `halted` = 1 and all enables 0. `trap_cause` holds.
  - Only `nrst` exits TRAP.
- **Wait counter:** 8 bits. Cleared on every state change and on each accepted access.
- **Rules for every state other than FETCH and MEM:**
  - `mem_ready` is ignored.
  - `mem_req`, `pc_wr`, `reg_wr` and `mdr_wr` are never asserted other than as listed above.

## Timing
- **Output timing:** Moore outputs, decoded from the registered state and `ir`. `ir` updates at the accepting edge of FETCH.
- **Cycle counts with zero-wait memory:**
  - R/ADDI: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch and JAL/JALR: 3 cycles.
  - Each memory wait cycle adds 1.
- **Handshake:** `mem_req` and `mem_addr_sel`/`mem_wr` stay stable from assertion until the cycle in which `mem_ready` is sampled high. Ready in the same cycle as the request is accepted.
- **Timeout vs. ready:** `mem_ready` arriving on the timeout cycle wins over the trap.
- **Reset mid-access:** asynchronous. Outputs drop immediately, and the in-flight access is abandoned with no write completion guaranteed.

## Structure
- **Shared package (`def`):**
  - Opcode constants.
  - funct3 codes: ADD_SUB, AND, OR, XOR, SLT, BEQ, BNE.
  - SUB funct7.
  - ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, ADDI 6.
  - State encoding.
  - `pc_src`, `memtoreg` and `trap_cause` encodings.
- **Sub-module:** one, `mem_wait_timer`. It holds the wait counter and compare and exposes clear, enable and expired.

## Test plan
- Reset release, memory returns 0x002081B3 (add x3,x1,x2) with ready immediate -> IDLE, FETCH, DECODE, EXEC (`alu_op` = 0), WB (`reg_wr` = 1, `memtoreg` = 00); back in FETCH 5 cycles after reset release.
- Fetch 0x402081B3 -> EXEC `alu_op` = 1 (SUB). Fetch 0x00402283 (lw x5,4(x0)) with data ready after 3 waits -> MEM lasts 4 cycles, `mdr_wr` pulses once, then WB with `memtoreg` = 01.
- Fetch 0x00000063 (beq) with `zero` = 1 -> `pc_wr` = 1, `pc_src` = 01 in EXEC. Fetch 0x00001063 (bne) with `zero` = 1 -> `pc_wr` stays 0 in EXEC.
- Fetch 0x00502423 (sw) -> MEM `mem_wr` = 1, `mem_addr_sel` = 1; no `reg_wr` at any point; next state FETCH.
- Fetch 0xFFFFFFFF -> TRAP after DECODE, `halted` = 1, `trap_cause` = 01; no `mem_req` for 20 cycles; `nrst` pulse returns to IDLE with `trap_cause` = 00.
- `mem_ready` held low in FETCH with `MEM_TIMEOUT` = 4 -> TRAP with cause 10 after 4 FETCH cycles. Repeat with ready on the 4th cycle -> no trap. Assert `nrst` mid-MEM -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mc_sequencer_pkg.sv
// Shared encodings for the multi-cycle RV32 subset controller: opcodes, funct
// fields, ALU codes, FSM states and the datapath select/trap encodings.
package def;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_ADDI = 3'd6;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    localparam logic [1:0] PC_SRC_PC4    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    localparam logic [1:0] TRAP_NONE     = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL  = 2'b01;
    localparam logic [1:0] TRAP_FETCH_TO = 2'b10;
    localparam logic [1:0] TRAP_DATA_TO  = 2'b11;

    function automatic logic opcode_legal(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_BRANCH) ||
               (op == OP_JAL)   || (op == OP_JALR) || (op == OP_LOAD)   ||
               (op == OP_STORE);
    endfunction

    function automatic logic [2:0] rtype_alu_op(input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            F3_ADD_SUB: return (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
            F3_AND:     return ALU_AND;
            F3_OR:      return ALU_OR;
            F3_XOR:     return ALU_XOR;
            F3_SLT:     return ALU_SLT;
            default:    return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_sequencer_mem_wait_timer.sv
// Counts cycles spent waiting on the shared memory port; expired flags the
// last cycle an access may still complete before the controller traps.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle controller for the RV32 subset core: sequences fetch, decode,
// execute, memory and writeback over a shared ready-handshaked memory port.
module mc_sequencer
    import def::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        mem_req,
    output logic        mem_addr_sel,
    output logic        mem_wr,
    output logic [31:0] ir,
    output logic        pc_wr,
    output logic [1:0]  pc_src,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        mdr_wr,
    output logic        reg_wr,
    output logic [1:0]  memtoreg,
    output logic        halted,
    output logic [1:0]  trap_cause
);

    logic [2:0]  state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [1:0]  cause_q, cause_d;
    logic        tmr_clr, tmr_en, tmr_expired;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_lw, is_sw;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];
    assign is_lw  = (opcode == OP_LOAD);
    assign is_sw  = (opcode == OP_STORE);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .nrst     (nrst),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                // Ready on the expiring cycle still completes the access.
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_FETCH_TO;
                end
            end
            ST_DECODE: begin
                if (opcode_legal(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI: state_d = ST_WB;
                    OP_LOAD, OP_STORE: state_d = ST_MEM;
                    default:           state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = is_lw ? ST_WB : ST_FETCH;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_DATA_TO;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    assign tmr_en  = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign tmr_clr = (state_d != state_q) || (tmr_en && mem_ready);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            ir_q    <= 32'd0;
            cause_q <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_wr       = 1'b0;
        pc_wr        = 1'b0;
        pc_src       = PC_SRC_PC4;
        alu_src      = 1'b0;
        alu_op       = ALU_ADD;
        mdr_wr       = 1'b0;
        reg_wr       = 1'b0;
        memtoreg     = M2R_ALU;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                pc_wr   = mem_ready;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_RTYPE: alu_op = rtype_alu_op(funct3, funct7);
                    OP_ADDI: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_ADDI;
                    end
                    OP_BRANCH: begin
                        alu_op = ALU_SUB;
                        if (((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero)) begin
                            pc_wr  = 1'b1;
                            pc_src = PC_SRC_BRANCH;
                        end
                    end
                    OP_JAL, OP_JALR: begin
                        reg_wr   = 1'b1;
                        memtoreg = M2R_PC4;
                        pc_wr    = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                        alu_src  = (opcode == OP_JALR);
                    end
                    OP_LOAD, OP_STORE: alu_src = 1'b1;
                    default: ;
                endcase
            end
            ST_MEM: begin
                // ALU controls stay as in EXEC so the data address is stable.
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_wr       = is_sw;
                alu_src      = 1'b1;
                mdr_wr       = is_lw && mem_ready;
            end
            ST_WB: begin
                reg_wr   = 1'b1;
                memtoreg = is_lw ? M2R_MDR : M2R_ALU;
            end
            default: ;
        endcase
    end

    assign ir         = ir_q;
    assign halted     = (state_q == ST_TRAP);
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Cycle-accurate bench for mc_sequencer: per-instruction vector table expanded
// into per-cycle stimulus and expected-output queues, plus trap/reset sequences.
module tb_mc_sequencer;

    typedef struct packed {
        logic       mem_req;
        logic       mem_addr_sel;
        logic       mem_wr;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       mdr_wr;
        logic       reg_wr;
        logic [1:0] memtoreg;
        logic       halted;
        logic [1:0] trap_cause;
    } outs_t;

    typedef struct {
        logic        rdy;
        logic [31:0] rdata;
    } stim_t;

    typedef struct {
        outs_t       o;
        logic        chk_ir;
        logic [31:0] ir;
        string       tag;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          fwait;
        int          mwait;
        outs_t       ex;
        logic        has_mem;
        logic        is_lw;
        logic        is_sw;
        logic        has_wb;
        logic [1:0]  wb_m2r;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        mem_req, mem_addr_sel, mem_wr, pc_wr, alu_src, mdr_wr, reg_wr, halted;
    logic [31:0] ir;
    logic [1:0]  pc_src, memtoreg, trap_cause;
    logic [2:0]  alu_op;

    int total = 0;
    int bad = 0;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    vec_t  tbl[16];

    mc_sequencer #(
        .MEM_TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .zero        (zero),
        .mem_req     (mem_req),
        .mem_addr_sel(mem_addr_sel),
        .mem_wr      (mem_wr),
        .ir          (ir),
        .pc_wr       (pc_wr),
        .pc_src      (pc_src),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .mdr_wr      (mdr_wr),
        .reg_wr      (reg_wr),
        .memtoreg    (memtoreg),
        .halted      (halted),
        .trap_cause  (trap_cause)
    );

    always #5 clk = ~clk;

    function automatic outs_t cur();
        outs_t o;
        o.mem_req      = mem_req;
        o.mem_addr_sel = mem_addr_sel;
        o.mem_wr       = mem_wr;
        o.pc_wr        = pc_wr;
        o.pc_src       = pc_src;
        o.alu_src      = alu_src;
        o.alu_op       = alu_op;
        o.mdr_wr       = mdr_wr;
        o.reg_wr       = reg_wr;
        o.memtoreg     = memtoreg;
        o.halted       = halted;
        o.trap_cause   = trap_cause;
        return o;
    endfunction

    function automatic outs_t o_fetch(logic acc);
        outs_t o = '0;
        o.mem_req = 1'b1;
        o.pc_wr   = acc;
        return o;
    endfunction

    function automatic outs_t o_mem(logic wr, logic mdr);
        outs_t o = '0;
        o.mem_req      = 1'b1;
        o.mem_addr_sel = 1'b1;
        o.mem_wr       = wr;
        o.alu_src      = 1'b1;
        o.mdr_wr       = mdr;
        return o;
    endfunction

    function automatic outs_t o_wb(logic [1:0] m2r);
        outs_t o = '0;
        o.reg_wr   = 1'b1;
        o.memtoreg = m2r;
        return o;
    endfunction

    function automatic outs_t o_trap(logic [1:0] cause);
        outs_t o = '0;
        o.halted     = 1'b1;
        o.trap_cause = cause;
        return o;
    endfunction

    function automatic outs_t ex(logic asrc, logic [2:0] aop, logic pcw, logic [1:0] pcs,
                                 logic rw, logic [1:0] m2r);
        outs_t o = '0;
        o.alu_src  = asrc;
        o.alu_op   = aop;
        o.pc_wr    = pcw;
        o.pc_src   = pcs;
        o.reg_wr   = rw;
        o.memtoreg = m2r;
        return o;
    endfunction

    function automatic vec_t mkv(logic [31:0] instr, logic z, int fw, int mw, outs_t e,
                                 logic hm, logic lw, logic sw, logic hw, logic [1:0] m2r,
                                 string name);
        vec_t v;
        v.instr = instr; v.zero = z; v.fwait = fw; v.mwait = mw; v.ex = e;
        v.has_mem = hm; v.is_lw = lw; v.is_sw = sw; v.has_wb = hw; v.wb_m2r = m2r;
        v.name = name;
        return v;
    endfunction

    task automatic push(logic rdy, logic [31:0] rdata, outs_t o, string tag,
                        logic chk_ir = 1'b0, logic [31:0] ir_exp = 32'd0);
        stim_t s;
        exp_t  e;
        s.rdy = rdy; s.rdata = rdata;
        e.o = o; e.chk_ir = chk_ir; e.ir = ir_exp; e.tag = tag;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic compare(outs_t exp_o, string tag);
        outs_t got;
        got = cur();
        total++;
        if (got !== exp_o) begin
            bad++;
            $display("FAIL %s: outputs got=%b want=%b", tag, got, exp_o);
        end
    endtask

    task automatic compare_ir(logic [31:0] want, string tag);
        total++;
        if (ir !== want) begin
            bad++;
            $display("FAIL %s: ir got=%h want=%h", tag, ir, want);
        end
    endtask

    task automatic run_queue();
        stim_t s;
        exp_t  e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk);
            mem_ready = s.rdy;
            mem_rdata = s.rdata;
            #1;
            e = exp_q.pop_front();
            compare(e.o, e.tag);
            if (e.chk_ir) compare_ir(e.ir, e.tag);
        end
    endtask

    task automatic queue_instr(vec_t v);
        string n;
        n = v.name;
        for (int i = 0; i < v.fwait; i++) push(1'b0, $urandom, o_fetch(1'b0), {n, "_fetch_wait"});
        push(1'b1, v.instr, o_fetch(1'b1), {n, "_fetch_acc"});
        push(1'($urandom_range(0, 1)), $urandom, '0, {n, "_decode"}, 1'b1, v.instr);
        push(1'($urandom_range(0, 1)), $urandom, v.ex, {n, "_exec"});
        if (v.has_mem) begin
            for (int i = 0; i < v.mwait; i++) push(1'b0, $urandom, o_mem(v.is_sw, 1'b0), {n, "_mem_wait"});
            push(1'b1, 32'hDEADBEEF, o_mem(v.is_sw, v.is_lw), {n, "_mem_acc"});
        end
        if (v.has_wb) push(1'($urandom_range(0, 1)), $urandom, o_wb(v.wb_m2r), {n, "_wb"});
    endtask

    // Asserts nrst mid-cycle, checks the asynchronous drop, then releases
    // on a falling edge and checks the single IDLE cycle.
    task automatic reset_and_idle(string tag);
        #2 nrst = 1'b0;
        #1;
        compare('0, {tag, "_in_reset"});
        compare_ir(32'd0, {tag, "_in_reset"});
        @(negedge clk);
        nrst      = 1'b1;
        mem_ready = 1'b1;
        #1;
        compare('0, {tag, "_idle"});
    endtask

    initial begin
        tbl[0]  = mkv(32'h002081B3, 1'b0, 0, 0, ex(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 2'b00), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, "add");
        tbl[1]  = mkv(32'h402081B3, 1'b0, 0, 0, ex(1'b0, 3'd1, 1'b0, 2'b00, 1'b0, 2'b00), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, "sub");
        tbl[2]  = mkv(32'h00402283, 1'b0, 0, 3, ex(1'b1, 3'd0, 1'b0, 2'b00, 1'b0, 2'b00), 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, "lw");
        tbl[3]  = mkv(32'h00000063, 1'b1, 0, 0, ex(1'b0, 3'd1, 1'b1, 2'b01, 1'b0, 2'b00), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, "beq_taken");
        tbl[4]  = mkv(32'h00001063, 1'b1, 0, 0, ex(1'b0, 3'd1, 1'b0, 2'b00, 1'b0, 2'b00), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, "bne_not");
        tbl[5]  = mkv(32'h00502423, 1'b0, 1, 1, ex(1'b1, 3'd0, 1'b0, 2'b00, 1'b0, 2'b00), 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, "sw");
        tbl[6]  = mkv(32'h00500093, 1'b0, 3, 0, ex(1'b1, 3'd6, 1'b0, 2'b00, 1'b0, 2'b00), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, "addi_late");
        tbl[7]  = mkv(32'h0020F1B3, 1'b0, 0, 0, ex(1'b0, 3'd2, 1'b0, 2'b00, 1'b0, 2'b00), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, "and");
        tbl[8]  = mkv(32'h0020E1B3, 1'b0, 2, 0, ex(1'b0, 3'd3, 1'b0, 2'b00, 1'b0, 2'b00), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, "or");
        tbl[9]  = mkv(32'h0020C1B3, 1'b0, 0, 0, ex(1'b0, 3'd4, 1'b0, 2'b00, 1'b0, 2'b00), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, "xor");
        tbl[10] = mkv(32'h0020A1B3, 1'b0, 0, 0, ex(1'b0, 3'd5, 1'b0, 2'b00, 1'b0, 2'b00), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, "slt");
        tbl[11] = mkv(32'h008000EF, 1'b0, 0, 0, ex(1'b0, 3'd0, 1'b1, 2'b10, 1'b1, 2'b10), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, "jal");
        tbl[12] = mkv(32'h000080E7, 1'b0, 0, 0, ex(1'b1, 3'd0, 1'b1, 2'b10, 1'b1, 2'b10), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, "jalr");
        tbl[13] = mkv(32'h00000063, 1'b0, 0, 0, ex(1'b0, 3'd1, 1'b0, 2'b00, 1'b0, 2'b00), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, "beq_not");
        tbl[14] = mkv(32'h00001063, 1'b0, 0, 0, ex(1'b0, 3'd1, 1'b1, 2'b01, 1'b0, 2'b00), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, "bne_taken");
        tbl[15] = mkv(32'h0020B1B3, 1'b0, 0, 2, ex(1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 2'b00), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, "sltu_as_add");

        // Power-on reset, then the IDLE cycle right after release.
        repeat (2) @(negedge clk);
        #1;
        compare('0, "por_in_reset");
        compare_ir(32'd0, "por_in_reset");
        @(negedge clk);
        nrst      = 1'b1;
        mem_ready = 1'b1;
        #1;
        compare('0, "por_idle");

        for (int i = 0; i < 16; i++) begin
            zero = tbl[i].zero;
            queue_instr(tbl[i]);
            run_queue();
        end

        // Illegal opcode: trap is sticky and ignores memory for 20 cycles.
        push(1'b1, 32'hFFFFFFFF, o_fetch(1'b1), "illegal_fetch");
        push(1'b1, $urandom, '0, "illegal_decode", 1'b1, 32'hFFFFFFFF);
        for (int i = 0; i < 20; i++) push(1'($urandom_range(0, 1)), $urandom, o_trap(2'b01), "illegal_trap");
        run_queue();
        reset_and_idle("illegal_reset");

        // Fetch timeout: four unanswered FETCH cycles.
        for (int i = 0; i < 4; i++) push(1'b0, $urandom, o_fetch(1'b0), "fto_fetch_wait");
        for (int i = 0; i < 3; i++) push(1'($urandom_range(0, 1)), $urandom, o_trap(2'b10), "fto_trap");
        run_queue();
        reset_and_idle("fto_reset");

        // Data timeout on a load.
        zero = 1'b0;
        push(1'b1, 32'h00402283, o_fetch(1'b1), "dto_fetch");
        push(1'b0, $urandom, '0, "dto_decode", 1'b1, 32'h00402283);
        push(1'b0, $urandom, ex(1'b1, 3'd0, 1'b0, 2'b00, 1'b0, 2'b00), "dto_exec");
        for (int i = 0; i < 4; i++) push(1'b0, $urandom, o_mem(1'b0, 1'b0), "dto_mem_wait");
        for (int i = 0; i < 2; i++) push(1'($urandom_range(0, 1)), $urandom, o_trap(2'b11), "dto_trap");
        run_queue();
        reset_and_idle("dto_reset");

        // Reset asserted while a load is waiting in MEM, then recovery.
        push(1'b1, 32'h00402283, o_fetch(1'b1), "midmem_fetch");
        push(1'b0, $urandom, '0, "midmem_decode", 1'b1, 32'h00402283);
        push(1'b0, $urandom, ex(1'b1, 3'd0, 1'b0, 2'b00, 1'b0, 2'b00), "midmem_exec");
        push(1'b0, $urandom, o_mem(1'b0, 1'b0), "midmem_mem_wait");
        run_queue();
        reset_and_idle("midmem_reset");
        zero = tbl[0].zero;
        queue_instr(tbl[0]);
        run_queue();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1);
    end

endmodule
